// File: rtl/dii_package.sv
// Debug interconnect flit type shared by ring stages and local debug modules.
package dii_package;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

endpackage

// File: rtl/debug_ring_arbiter.sv
// Two-input debug ring merge point: packet-locked round-robin between ring
// pass-through and local injection, with a registered output stage.
//
// state | meaning
// IDLE  | no packet in flight; arbitrate between valid inputs
// LOCK0 | ring packet in progress; only ring_in may transfer
// LOCK1 | local packet in progress; only local_in may transfer
module debug_ring_arbiter
   import dii_package::*;
#(
   parameter int PRIO_INIT = 0,
   parameter int CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  dii_flit                ring_in,
   output logic                   ring_in_ready,
   input  dii_flit                local_in,
   output logic                   local_in_ready,
   output dii_flit                out,
   input  logic                   out_ready,
   output logic [1:0][CNT_W-1:0]  pkt_cnt
);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t                 state_q, state_d;
   logic                   prio_q, prio_d;
   dii_flit                out_q, out_d;
   logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;

   logic    can_load;
   logic    gnt;
   logic    gnt_vld;
   logic    xfer;
   dii_flit sel;

   always_comb begin
      can_load = !out_q.valid || out_ready;
      gnt      = 1'b0;
      gnt_vld  = 1'b0;
      case (state_q)
         LOCK0: begin
            gnt     = 1'b0;
            gnt_vld = 1'b1;
         end
         LOCK1: begin
            gnt     = 1'b1;
            gnt_vld = 1'b1;
         end
         default: begin
            if (ring_in.valid && local_in.valid) gnt = prio_q;
            else                                 gnt = local_in.valid;
            gnt_vld = ring_in.valid || local_in.valid;
         end
      endcase

      sel = gnt ? local_in : ring_in;
      // Readies are gated by rst so nothing is accepted while reset is held.
      ring_in_ready  = rst && can_load && gnt_vld && !gnt;
      local_in_ready = rst && can_load && gnt_vld && gnt;
      xfer           = sel.valid && (ring_in_ready || local_in_ready);

      state_d = state_q;
      prio_d  = prio_q;
      out_d   = out_q;
      cnt_d   = cnt_q;

      if (can_load) out_d = xfer ? sel : '0;

      if (xfer) begin
         if (sel.last) begin
            state_d    = IDLE;
            prio_d     = ~gnt;
            cnt_d[gnt] = cnt_q[gnt] + CNT_W'(1);
         end else begin
            state_d = gnt ? LOCK1 : LOCK0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         prio_q  <= (PRIO_INIT != 0);
         out_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out     = out_q;
   assign pkt_cnt = cnt_q;

endmodule

// File: tb/tb_debug_ring_arbiter.sv
// Scoreboard bench for debug_ring_arbiter: packet-level arbitration model plus
// an output monitor that pops expected flits as they leave the DUT.
module tb_debug_ring_arbiter;
   import dii_package::*;

   localparam int CNT_W     = 4;
   localparam int PRIO_INIT = 0;

   logic                  clk = 1'b0;
   logic                  rst;
   dii_flit               ring_in, local_in, out;
   logic                  ring_in_ready, local_in_ready, out_ready;
   logic [1:0][CNT_W-1:0] pkt_cnt;

   always #5 clk = ~clk;

   debug_ring_arbiter #(.PRIO_INIT(PRIO_INIT), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .ring_in        (ring_in),
      .ring_in_ready  (ring_in_ready),
      .local_in       (local_in),
      .local_in_ready (local_in_ready),
      .out            (out),
      .out_ready      (out_ready),
      .pkt_cnt        (pkt_cnt)
   );

   int      n_tests = 0;
   int      n_fail  = 0;
   dii_flit ring_src[$];
   dii_flit loc_src[$];
   dii_flit exp_q[$];
   int      out_log[$];
   int      bubble_pct = 0;
   int      rdy_pct    = 100;
   int      rdy_force  = -1;
   bit      ring_pres, loc_pres;

   // reference model state: packet owner (-1 = none), priority, counts
   int      m_owner = -1;
   int      m_prio  = PRIO_INIT;
   int      m_cnt[2] = '{0, 0};
   bit      m_outv  = 1'b0;
   bit      m_can, m_gv, m_er, m_el, m_x;
   int      m_g;
   dii_flit m_f;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("rst_ready", 32'({ring_in_ready, local_in_ready}), 32'd0);
         check("rst_out_valid", 32'(out.valid), 32'd0);
         check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
         m_owner = -1;
         m_prio  = PRIO_INIT;
         m_cnt   = '{0, 0};
         m_outv  = 1'b0;
         exp_q.delete();
      end else begin
         m_can = !m_outv || out_ready;
         if (m_owner < 0) begin
            m_gv = ring_in.valid || local_in.valid;
            m_g  = (ring_in.valid && local_in.valid) ? m_prio : (local_in.valid ? 1 : 0);
         end else begin
            m_gv = 1'b1;
            m_g  = m_owner;
         end
         m_er = m_gv && m_can && (m_g == 0);
         m_el = m_gv && m_can && (m_g == 1);
         check("ready", 32'({ring_in_ready, local_in_ready}), 32'({m_er, m_el}));
         check("pkt_cnt", 32'(pkt_cnt), 32'({CNT_W'(m_cnt[1]), CNT_W'(m_cnt[0])}));
         m_f = (m_g == 1) ? local_in : ring_in;
         m_x = m_gv && m_can && m_f.valid;
         if (m_can) m_outv = m_x;
         if (m_x) begin
            exp_q.push_back(m_f);
            if (m_f.last) begin
               m_cnt[m_g] = (m_cnt[m_g] + 1) % (1 << CNT_W);
               m_prio     = 1 - m_g;
               m_owner    = -1;
            end else begin
               m_owner = m_g;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst && out.valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL out_unexpected: got %h, expected no flit at %0t", out.data, $time);
         end else begin
            check("out_flit", 32'({out.last, out.data}), 32'({exp_q[0].last, exp_q[0].data}));
            if (out_ready) begin
               if (out.last) out_log.push_back(int'(out.data[15:12]));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      bit tr, tl;
      @(negedge clk);
      tr = ring_in.valid && ring_in_ready;
      tl = local_in.valid && local_in_ready;
      @(posedge clk);
      #1;
      if (tr) begin void'(ring_src.pop_front()); ring_pres = 1'b0; end
      if (tl) begin void'(loc_src.pop_front());  loc_pres  = 1'b0; end
      if (!ring_pres && ring_src.size() > 0) ring_pres = ($urandom_range(0, 99) >= bubble_pct);
      if (!loc_pres && loc_src.size() > 0)   loc_pres  = ($urandom_range(0, 99) >= bubble_pct);
      ring_in  = ring_pres ? ring_src[0] : '0;
      local_in = loc_pres  ? loc_src[0]  : '0;
      out_ready = (rdy_force >= 0) ? (rdy_force != 0) : ($urandom_range(0, 99) < rdy_pct);
   endtask

   task automatic push_pkt(input bit src, input int len, input logic [15:0] base);
      dii_flit f;
      for (int i = 0; i < len; i++) begin
         f.valid = 1'b1;
         f.last  = (i == len - 1);
         f.data  = base + 16'(i);
         if (src) loc_src.push_back(f);
         else     ring_src.push_back(f);
      end
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while ((ring_src.size() > 0 || loc_src.size() > 0 || exp_q.size() > 0 || out.valid) && c < budget) begin
         step();
         c++;
      end
      check("drain_timeout", 32'(c < budget), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("reset_out_valid", 32'(out.valid), 32'd0);
      check("reset_ready", 32'({ring_in_ready, local_in_ready}), 32'd0);
      ring_src.delete();
      loc_src.delete();
      out_log.delete();
      ring_pres  = 1'b0;
      loc_pres   = 1'b0;
      ring_in    = '0;
      local_in   = '0;
      out_ready  = 1'b0;
      rdy_force  = -1;
      bubble_pct = 0;
      rdy_pct    = 100;
      repeat (2) step();
      #2 rst = 1'b1;
   endtask

   initial begin
      int guard;
      rst       = 1'b0;
      ring_in   = '0;
      local_in  = '0;
      out_ready = 1'b0;

      // single-flit contention with ring holding priority
      do_reset();
      rdy_force = 1;
      push_pkt(0, 1, 16'h1111);
      push_pkt(1, 1, 16'h2222);
      drain(200);
      check("contention_cnt", 32'(pkt_cnt), 32'({4'd1, 4'd1}));

      // multi-flit ring packet blocks a waiting local flit
      do_reset();
      rdy_force = 1;
      push_pkt(0, 3, 16'h00A0);
      push_pkt(1, 1, 16'h00B0);
      drain(200);
      check("lock_cnt", 32'(pkt_cnt), 32'({4'd1, 4'd1}));

      // backpressure for 5 cycles in the middle of a ring packet
      do_reset();
      rdy_force = 1;
      push_pkt(0, 4, 16'h0C00);
      push_pkt(1, 2, 16'h0D00);
      repeat (3) step();
      rdy_force = 0;
      repeat (5) step();
      rdy_force = 1;
      drain(200);
      check("bp_cnt", 32'(pkt_cnt), 32'({4'd1, 4'd1}));

      // saturation: 2-flit packets alternate strictly
      do_reset();
      rdy_force = 1;
      for (int i = 0; i < 10; i++) begin
         push_pkt(0, 2, 16'h1000 + 16'(i * 2));
         push_pkt(1, 2, 16'h2000 + 16'(i * 2));
      end
      drain(500);
      check("sat_cnt", 32'(pkt_cnt), 32'({4'd10, 4'd10}));
      check("sat_pkts", 32'(out_log.size()), 32'd20);
      for (int i = 0; i < out_log.size(); i++)
         check("sat_alternate", 32'(out_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

      // counter wrap at CNT_W=4
      do_reset();
      rdy_force = 1;
      for (int i = 0; i < 17; i++) push_pkt(1, 1, 16'h5000 + 16'(i));
      drain(500);
      check("wrap_cnt1", 32'(pkt_cnt[1]), 32'd1);
      check("wrap_cnt0", 32'(pkt_cnt[0]), 32'd0);

      // reset after the second flit of a 4-flit ring packet
      do_reset();
      rdy_force = 1;
      push_pkt(0, 4, 16'h3000);
      guard = 0;
      while (ring_src.size() > 2 && guard < 50) begin
         step();
         guard++;
      end
      check("midrst_reach", 32'(guard < 50), 32'd1);
      #2;
      do_reset();
      rdy_force = 1;
      push_pkt(1, 1, 16'h4000);
      step();
      #1;
      check("post_rst_grant", 32'({local_in.valid, local_in_ready}), 32'b11);
      drain(200);
      check("midrst_cnt", 32'(pkt_cnt), 32'({4'd1, 4'd0}));

      // randomized traffic with bubbles and random downstream stalls
      do_reset();
      bubble_pct = 30;
      rdy_pct    = 70;
      for (int i = 0; i < 60; i++)
         push_pkt(1'($urandom_range(0, 1)), $urandom_range(1, 4), 16'($urandom));
      drain(5000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
   end

endmodule
